// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, ready-acknowledged IMEM port and IF/ID register.
// A one-entry skid buffer absorbs the fetch that lands while decode holds.
module if_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP      = 16'h0000
) (
   input  logic        CLK,
   input  logic        RESET_N,
   output logic        IMEM_REQ,
   output logic [15:0] IMEM_ADDR,
   input  logic        IMEM_RDY,
   input  logic [15:0] IMEM_DATA,
   input  logic        HOLD,
   input  logic        STALL,
   input  logic [15:0] PC_OFFSET,
   output logic [15:0] IR,
   output logic [15:0] NPC,
   output logic        IR_VALID
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      BUFFERED
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] npc_q, npc_d;
   logic [15:0] buf_q, buf_d;
   logic        ir_valid_q, ir_valid_d;
   logic        xfer;
   logic        redirect;

   assign IMEM_REQ  = (state_q == FETCH);
   assign IMEM_ADDR = pc_q;
   assign IR        = ir_q;
   assign NPC       = npc_q;
   assign IR_VALID  = ir_valid_q;

   assign xfer     = IMEM_REQ && IMEM_RDY;
   assign redirect = STALL && ir_valid_q && !HOLD;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      npc_d      = npc_q;
      buf_d      = buf_q;
      ir_valid_d = ir_valid_q;
      if (redirect) begin
         // wrong-path fetch (if any) this cycle is dropped
         pc_d       = npc_q + PC_OFFSET;
         ir_d       = NOP;
         ir_valid_d = 1'b0;
         buf_d      = NOP;
         state_d    = FETCH;
      end else begin
         unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (xfer && !HOLD) begin
                  ir_d       = IMEM_DATA;
                  npc_d      = pc_q + 16'd1;
                  ir_valid_d = 1'b1;
                  pc_d       = pc_q + 16'd1;
               end else if (xfer) begin
                  buf_d   = IMEM_DATA;
                  pc_d    = pc_q + 16'd1;
                  state_d = BUFFERED;
               end else if (!HOLD) begin
                  ir_d       = NOP;
                  ir_valid_d = 1'b0;
               end
            end
            BUFFERED: begin
               if (!HOLD) begin
                  ir_d       = buf_q;
                  npc_d      = pc_q;
                  ir_valid_d = 1'b1;
                  state_d    = FETCH;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= NOP;
         npc_q      <= RESET_PC;
         buf_q      <= NOP;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         npc_q      <= npc_d;
         buf_q      <= buf_d;
         ir_valid_q <= ir_valid_d;
      end
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit, 5-stage pipeline. Holds the PC and fetches one instruction per cycle through a ready-acknowledged instruction-memory port. Feeds the IF/ID pipeline register (IR, NPC, IR_VALID) consumed by decode. Redirects the PC on decode's taken-branch indication (STALL) and squashes the wrong-path fetch with a NOP bubble.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP, 16'h0000, bubble encoding driven on IR. It is a BR with nzp=000 and never taken.

- CLK  in  1  pipeline clock; all state updates on posedge.
- RESET_N  in  1  **one clock; reset is asynchronous and active-low.** Uses the codebase clock name CLK.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  16  word address of the fetch; equals PC.
- IMEM_RDY  in  1  same-cycle acknowledge. A transfer occurs on a cycle with IMEM_REQ && IMEM_RDY.
- IMEM_DATA  in  16  instruction word; valid on a transfer cycle.
- HOLD  in  1  decode cannot accept; freeze the IF/ID register.
- STALL  in  1  decode's taken-branch flag for the current IR.
- PC_OFFSET  in  16  sign-extended branch offset from decode.
- IR  out  16  IF/ID instruction register.
- NPC  out  16  IF/ID next-PC (address of IR + 1).
- IR_VALID  out  1  IR holds a real instruction, not a bubble.

## Operation
States: IDLE, FETCH, BUFFERED.

- **Reset (async, RESET_N=0):**
  - PC=RESET_PC, IR=NOP, NPC=RESET_PC, IR_VALID=0.
  - Skid buffer BUF=NOP. State IDLE.
  - IMEM_REQ=0, IMEM_ADDR=PC.
- **IDLE:** IMEM_REQ=0. Next state FETCH unconditionally.
- **FETCH:** IMEM_REQ=1, IMEM_ADDR=PC.
  - Transfer && !HOLD: IR<=IMEM_DATA, NPC<=PC+1, IR_VALID<=1, PC<=PC+1. Stay FETCH.
  - Transfer && HOLD: BUF<=IMEM_DATA, PC<=PC+1. IF/ID unchanged. Go to BUFFERED.
  - No transfer && !HOLD: IR<=NOP, IR_VALID<=0 (bubble); NPC unchanged.
  - No transfer && HOLD: no change.
- **BUFFERED:** IMEM_REQ=0.
  - !HOLD: IR<=BUF, NPC<=PC, IR_VALID<=1. Go to FETCH.
  - HOLD: no change.
- **Redirect:** redirect = STALL && IR_VALID && !HOLD. It overrides all rules above, in any state:
  - PC<=NPC+PC_OFFSET.
  - IR<=NOP, IR_VALID<=0.
  - BUF discarded. Next state FETCH.
  - Any IMEM transfer in the same cycle is dropped.
- **Gating:** STALL is ignored when IR_VALID=0 or HOLD=1.
- **Arithmetic:** all PC arithmetic is 16-bit modulo 2^16. 16'hFFFF+1 wraps to 16'h0000; offsets wrap both directions.
- **Reset mid-operation:** returns immediately to reset values. Any pending or buffered instruction is lost.

## Timing
- The first request is issued in the second cycle after RESET_N deasserts (the IDLE cycle comes first).
- Fetch latency: transfer at edge t → IR/IR_VALID updated at t+1. Throughput is 1 instruction/cycle while IMEM_RDY=1 and HOLD=0.
- Taken branch: STALL seen at edge t → IMEM_ADDR=target during cycle t+1. The earliest target instruction reaches IR at t+2 (1 bubble).
- HOLD freezes IR, NPC and IR_VALID in the same cycle. At most one instruction is buffered, so the stage never requests while BUFFERED.
- IMEM_ADDR may change on any cycle without a transfer. The memory must not depend on address stability across unacknowledged cycles.

## Test plan
- **Reset then stream:** RESET_N low 3 cycles, then IMEM_RDY=1, memory[i]=16'h1000+i. Expect:
  - IMEM_REQ=0 for the first post-reset cycle.
  - Then IR=16'h1000, 16'h1001, … on consecutive cycles, with NPC=1, 2, … and IR_VALID=1.
- **Wait states:** IMEM_RDY low 2 cycles at PC=5. Expect IR=NOP, IR_VALID=0 for 2 cycles, IMEM_ADDR held at 5, then IR=memory[5], NPC=6.
- **HOLD with skid:** HOLD=1 on a cycle where the PC=3 transfer occurs, held 3 cycles. Expect:
  - IR frozen.
  - State BUFFERED, IMEM_REQ=0.
  - After release, IR=memory[3], NPC=4.
  - Next IMEM_ADDR=4. No instruction lost or duplicated.
- **Taken branch:** IR valid, NPC=16'h0010, PC_OFFSET=16'hFFF8, STALL=1. Expect:
  - Next cycle IR=NOP, IR_VALID=0, IMEM_ADDR=16'h0008.
  - Following IR=memory[8].
  - With HOLD=1 or IR_VALID=0 instead, STALL produces no redirect.
- **Wrap:** RESET_PC=16'hFFFF. Expect NPC=16'h0000 and next IMEM_ADDR=16'h0000. Branch with NPC=16'hFFFE, PC_OFFSET=16'h0005 targets 16'h0003.
- **Reset mid-operation:** assert RESET_N while BUFFERED with HOLD=1. Expect IR=NOP, IR_VALID=0, IMEM_REQ=0, PC=RESET_PC immediately, without waiting for a clock edge.
